// File: rtl/ptr_table_ctrl_if.sv
// ptr_table_ctrl_if: bundles the request, response and pointer-RAM buses of
// ptr_table_ctrl.
//   req_*  : lookup request from the hash unit (valid/ready handshake)
//   rsp_*  : hit/literal decision to the packer (valid/ready handshake)
//   mem_*  : external single-port synchronous RAM (read data one cycle late)
// modport master : the controller side (ptr_table_ctrl)
// modport slave  : the surrounding hash unit, packer and RAM
interface ptr_table_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned POS_W  = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_hash;
  logic [POS_W-1:0]  req_pos;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [POS_W-1:0]  mem_wdata;
  logic [POS_W-1:0]  mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [ADDR_W-1:0] rsp_offset;
  logic [POS_W-1:0]  rsp_old_pos;

  modport master (
    input  req_valid, req_hash, req_pos, mem_rdata, rsp_ready,
    output req_ready, mem_addr, mem_we, mem_wdata,
           rsp_valid, rsp_hit, rsp_offset, rsp_old_pos
  );

  modport slave (
    output req_valid, req_hash, req_pos, mem_rdata, rsp_ready,
    input  req_ready, mem_addr, mem_we, mem_wdata,
           rsp_valid, rsp_hit, rsp_offset, rsp_old_pos
  );
endinterface

// File: rtl/ptr_table_ctrl.sv
// ptr_table_ctrl: owns the LZRW1 hash-indexed pointer table held in an
// external single-port synchronous RAM.
//   - Clears every entry to 0 (empty) after reset and on each start.
//   - Per request: reads table[hash], writes the current position back, and
//     reports hit/offset/old entry to the packer.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   start        : begin a new block (table clear), honoured only in READY
//   busy         : high whenever the controller is not in READY
//   bus          : req/rsp handshakes and RAM bus (ptr_table_ctrl_if.master)
module ptr_table_ctrl #(
  parameter int unsigned TABLESIZE  = 4096,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned POS_W      = 32,
  parameter int unsigned MAX_OFFSET = 4095
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  ptr_table_ctrl_if.master     bus
);

  typedef enum logic [1:0] {CLEAR, READY, LOOKUP, RESP} state_t;

  localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(TABLESIZE);

  state_t            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [POS_W-1:0]  pos_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic [ADDR_W-1:0] rsp_offset_q;
  logic [POS_W-1:0]  rsp_old_q;

  // Hit decision, evaluated while the read data for the accepted hash is on
  // mem_rdata (LOOKUP). pos_q doubles as the write-back data.
  logic [POS_W-1:0]  diff_d;
  logic              hit_d;

  always_comb begin
    diff_d = pos_q - bus.mem_rdata;
    hit_d  = (bus.mem_rdata != '0) && (pos_q > bus.mem_rdata) &&
             (diff_d <= POS_W'(MAX_OFFSET));
  end

  // In READY the RAM address follows req_hash directly so the read is issued
  // in the accept cycle; start steals the cycle from any pending request.
  assign bus.mem_addr    = (state_q == READY) ? bus.req_hash : addr_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_wdata   = pos_q;
  assign bus.req_ready   = req_ready_q && !start;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_hit     = rsp_hit_q;
  assign bus.rsp_offset  = rsp_offset_q;
  assign bus.rsp_old_pos = rsp_old_q;
  assign busy            = busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      pos_q        <= '0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_offset_q <= '0;
      rsp_old_q    <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          // cnt_q is the next address to write; once it reaches TABLESIZE
          // the last entry is on the bus this cycle.
          if (cnt_q == CLR_END) begin
            state_q     <= READY;
            we_q        <= 1'b0;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= cnt_q[ADDR_W-1:0];
            pos_q  <= '0;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        READY: begin
          if (start) begin
            // Entry 0 is written in the first CLEAR cycle, so the counter
            // already points at entry 1.
            state_q     <= CLEAR;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            we_q        <= 1'b1;
            addr_q      <= '0;
            pos_q       <= '0;
            cnt_q       <= (ADDR_W + 1)'(1);
          end else if (bus.req_valid) begin
            state_q     <= LOOKUP;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            we_q        <= 1'b1;
            addr_q      <= bus.req_hash;
            pos_q       <= bus.req_pos;
          end
        end
        LOOKUP: begin
          state_q      <= RESP;
          we_q         <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_hit_q    <= hit_d;
          rsp_offset_q <= hit_d ? diff_d[ADDR_W-1:0] : '0;
          rsp_old_q    <= bus.mem_rdata;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= READY;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ptr_table_ctrl.sv
module tb_ptr_table_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  ptr_table_ctrl_if #(.ADDR_W(12), .POS_W(32)) bus ();

  ptr_table_ctrl #(
    .TABLESIZE(4096),
    .ADDR_W(12),
    .POS_W(32),
    .MAX_OFFSET(4095)
  ) dut (
    .clock(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .bus(bus)
  );

  // Synchronous single-port RAM, read-before-write, preloaded with garbage so
  // that an incomplete clear shows up as a non-zero old_pos.
  logic [31:0] ram [0:4095];
  initial for (int i = 0; i < 4096; i++) ram[i] = 32'hA500_0000 | i;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] hash;
    logic [31:0] pos;
    logic        hit;
    logic [11:0] off;
    logic [31:0] old;
    int          stall;
  } vec_t;

  // Called right after a negedge with reset/start just released.
  task automatic clear_check(input string tag);
    int good = 0;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1 && bus.mem_addr === 12'(k) && bus.mem_wdata === 32'd0 &&
          busy === 1'b1 && bus.req_ready === 1'b0)
        good++;
    end
    chk({tag, "_clear_cycles"}, 32'(good), 32'd4096);
    @(negedge clk);
    chk({tag, "_done_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Called right after a negedge. Issues one request and checks the
  // N+1 write, N+2 response, stall stability and handshake.
  task automatic do_req(input vec_t v);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      chk("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_hash  = v.hash;
    bus.req_pos   = v.pos;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("lookup_we", {31'd0, bus.mem_we}, 32'd1);
    chk("lookup_addr", {20'd0, bus.mem_addr}, {20'd0, v.hash});
    chk("lookup_wdata", bus.mem_wdata, v.pos);
    chk("lookup_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rsp_hit", {31'd0, bus.rsp_hit}, {31'd0, v.hit});
    chk("rsp_offset", {20'd0, bus.rsp_offset}, {20'd0, v.off});
    chk("rsp_old_pos", bus.rsp_old_pos, v.old);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_fields", {bus.rsp_hit, 7'd0, bus.rsp_offset, bus.rsp_old_pos[11:0]},
          {v.hit, 7'd0, v.off, v.old[11:0]});
      chk("stall_old_pos", bus.rsp_old_pos, v.old);
      chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{12'h123, 32'd5,    1'b0, 12'd0,    32'd0,    0};
    vecs[1]  = '{12'h123, 32'd20,   1'b1, 12'd15,   32'd5,    0};
    vecs[2]  = '{12'h010, 32'd1,    1'b0, 12'd0,    32'd0,    0};
    vecs[3]  = '{12'h010, 32'd4097, 1'b0, 12'd0,    32'd1,    0};
    vecs[4]  = '{12'h010, 32'd8192, 1'b1, 12'd4095, 32'd4097, 0};
    vecs[5]  = '{12'h020, 32'd0,    1'b0, 12'd0,    32'd0,    0};
    vecs[6]  = '{12'h020, 32'd7,    1'b0, 12'd0,    32'd0,    0};
    vecs[7]  = '{12'h030, 32'd100,  1'b0, 12'd0,    32'd0,    0};
    vecs[8]  = '{12'h030, 32'd50,   1'b0, 12'd0,    32'd100,  0};
    vecs[9]  = '{12'h030, 32'd50,   1'b0, 12'd0,    32'd50,   0};
    vecs[10] = '{12'hFFF, 32'd3,    1'b0, 12'd0,    32'd0,    0};
    vecs[11] = '{12'hFFF, 32'd4,    1'b1, 12'd1,    32'd3,    0};
    vecs[12] = '{12'h123, 32'd40,   1'b1, 12'd20,   32'd20,   5};

    bus.req_valid = 1'b0;
    bus.req_hash  = '0;
    bus.req_pos   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {20'd0, bus.mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rsp_fields", {bus.rsp_hit, 19'd0, bus.rsp_offset}, 32'd0);
    chk("rst_old_pos", bus.rsp_old_pos, 32'd0);
    reset = 1'b0;
    clear_check("init");

    for (int i = 0; i < 13; i++) do_req(vecs[i]);

    // start in READY with a request pending: start wins, table is cleared
    start = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_hash  = 12'h123;
    bus.req_pos   = 32'd77;
    #1;
    chk("start_blocks_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.req_valid = 1'b0;
    clear_check("start");
    do_req('{12'h123, 32'd50, 1'b0, 12'd0, 32'd0, 0});

    // Reset while a response is pending
    bus.req_valid = 1'b1;
    bus.req_hash  = 12'h200;
    bus.req_pos   = 32'd60;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_resp_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_resp_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    clear_check("rst2");
    do_req('{12'h200, 32'd61, 1'b0, 12'd0, 32'd0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
